// File: rtl/rtc_pps_discipline.sv
// Disciplines an RTC sub-second counter to a 1 PPS reference: hack, read back phase/speed,
// apply a clamped proportional ckspeed correction, and share the clock bus with a host port.
module rtc_pps_discipline #(
    parameter int          GAIN_SHIFT  = 4,
    parameter logic [31:0] MAX_STEP    = 32'd256,
    parameter logic [15:0] LOCK_THRESH = 16'd64,
    parameter int          LOCK_COUNT  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_pps,
    input  logic        i_host_stb,
    input  logic        i_host_we,
    input  logic [2:0]  i_host_addr,
    input  logic [31:0] i_host_data,
    input  logic [3:0]  i_host_sel,
    output logic        o_host_stall,
    output logic [31:0] o_host_data,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_data,
    output logic        o_hack,
    output logic [15:0] o_phase_err,
    output logic        o_update,
    output logic        o_locked,
    output logic        o_overrun
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HACK    = 4'd1,
        S_WAIT1   = 4'd2,
        S_WAIT2   = 4'd3,
        S_RD_TIME = 4'd4,
        S_RD_CNT  = 4'd5,
        S_RD_SPD  = 4'd6,
        S_CALC    = 4'd7,
        S_WR_SPD  = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    localparam logic signed [31:0] STEP_POS = $signed(MAX_STEP);
    localparam logic signed [31:0] STEP_NEG = -$signed(MAX_STEP);
    localparam logic [3:0]         LOCK_MAX = 4'(LOCK_COUNT);

    state_t      state_q, state_d;
    logic [2:0]  pps_sync_q, pps_sync_d;
    logic        enable_q, enable_d;
    logic [7:0]  phase_hi_q, phase_hi_d;
    logic [7:0]  phase_lo_q, phase_lo_d;
    logic [31:0] speed_q, speed_d;
    logic [15:0] phase_err_q, phase_err_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        locked_q, locked_d;
    logic        overrun_q, overrun_d;

    logic               pps_evt_s;
    logic [15:0]        err_s;
    logic signed [31:0] err_ext_s;
    logic signed [31:0] step_raw_s;
    logic signed [31:0] step_s;
    logic [31:0]        diff_s;
    logic [15:0]        err_mag_s;
    logic               in_lock_s;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            pps_sync_q  <= 3'd0;
            enable_q    <= 1'b0;
            phase_hi_q  <= 8'd0;
            phase_lo_q  <= 8'd0;
            speed_q     <= 32'd0;
            phase_err_q <= 16'd0;
            lock_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pps_sync_q  <= pps_sync_d;
            enable_q    <= enable_d;
            phase_hi_q  <= phase_hi_d;
            phase_lo_q  <= phase_lo_d;
            speed_q     <= speed_d;
            phase_err_q <= phase_err_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            overrun_q   <= overrun_d;
        end
    end

    // PPS synchroniser, edge detect and correction arithmetic.
    always_comb begin
        pps_sync_d = {pps_sync_q[1:0], i_pps};
        pps_evt_s  = pps_sync_q[1] & ~pps_sync_q[2];
        enable_d   = i_enable;

        err_s      = {phase_hi_q, phase_lo_q};
        err_ext_s  = {{16{err_s[15]}}, err_s};
        step_raw_s = err_ext_s >>> GAIN_SHIFT;
        if (step_raw_s > STEP_POS) begin
            step_s = STEP_POS;
        end else if (step_raw_s < STEP_NEG) begin
            step_s = STEP_NEG;
        end else begin
            step_s = step_raw_s;
        end
        // Lagging clock (negative error) must speed up, hence subtraction.
        diff_s = i_wb_data - $unsigned(step_s);

        if (phase_err_q[15]) begin
            err_mag_s = 16'd0 - phase_err_q;
        end else begin
            err_mag_s = phase_err_q;
        end
        in_lock_s = (err_mag_s < LOCK_THRESH);
    end

    // Sequencer next state, captures, lock and overrun tracking.
    always_comb begin
        state_d     = state_q;
        phase_hi_d  = phase_hi_q;
        phase_lo_d  = phase_lo_q;
        speed_d     = speed_q;
        phase_err_d = phase_err_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;

        case (state_q)
            S_IDLE: begin
                if (pps_evt_s && i_enable) begin
                    state_d = S_HACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HACK:    state_d = S_WAIT1;
            S_WAIT1:   state_d = S_WAIT2;
            S_WAIT2:   state_d = S_RD_TIME;
            S_RD_TIME: state_d = S_RD_CNT;
            S_RD_CNT: begin
                phase_hi_d = i_wb_data[7:0];
                state_d    = S_RD_SPD;
            end
            S_RD_SPD: begin
                phase_lo_d = i_wb_data[31:24];
                state_d    = S_CALC;
            end
            S_CALC: begin
                // A zero ckspeed would stop the clock outright.
                if (diff_s == 32'd0) begin
                    speed_d = 32'd1;
                end else begin
                    speed_d = diff_s;
                end
                phase_err_d = err_s;
                state_d     = S_WR_SPD;
            end
            S_WR_SPD:  state_d = S_DONE;
            S_DONE: begin
                if (!in_lock_s) begin
                    lock_cnt_d = 4'd0;
                end else if (lock_cnt_q == LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q;
                end else begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
                locked_d = (lock_cnt_d == LOCK_MAX);
                state_d  = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        if (!i_enable) begin
            lock_cnt_d = 4'd0;
            locked_d   = 1'b0;
        end else begin
            lock_cnt_d = lock_cnt_d;
        end

        if (pps_evt_s && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (i_enable && !enable_q) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Clock bus arbitration: host passes through only while the sequencer is idle.
    always_comb begin
        o_wb_stb     = 1'b0;
        o_wb_we      = 1'b0;
        o_wb_addr    = 3'd0;
        o_wb_data    = 32'd0;
        o_wb_sel     = 4'd0;
        o_host_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_wb_stb  = i_host_stb;
                o_wb_we   = i_host_we;
                o_wb_addr = i_host_addr;
                o_wb_data = i_host_data;
                o_wb_sel  = i_host_sel;
            end
            S_RD_TIME: begin
                o_host_stall = i_host_stb;
                o_wb_stb     = 1'b1;
                o_wb_addr    = 3'd5;
                o_wb_sel     = 4'hF;
            end
            S_RD_CNT: begin
                o_host_stall = i_host_stb;
                o_wb_stb     = 1'b1;
                o_wb_addr    = 3'd6;
                o_wb_sel     = 4'hF;
            end
            S_RD_SPD: begin
                o_host_stall = i_host_stb;
                o_wb_stb     = 1'b1;
                o_wb_addr    = 3'd4;
                o_wb_sel     = 4'hF;
            end
            S_WR_SPD: begin
                o_host_stall = i_host_stb;
                o_wb_stb     = 1'b1;
                o_wb_we      = 1'b1;
                o_wb_addr    = 3'd4;
                o_wb_data    = speed_q;
                o_wb_sel     = 4'hF;
            end
            default: begin
                o_host_stall = i_host_stb;
            end
        endcase
    end

    assign o_host_data = i_wb_data;
    assign o_hack      = (state_q == S_HACK);
    assign o_update    = (state_q == S_DONE);
    assign o_phase_err = phase_err_q;
    assign o_locked    = locked_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_rtc_pps_discipline.sv
// Scoreboard bench for rtc_pps_discipline: stimulus queues expected bus cycles and phase errors,
// a forked monitor pops and compares them whenever the DUT strobes the bus or pulses o_update.
module tb_rtc_pps_discipline;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n, en, pps;
    logic        h_stb, h_we;
    logic [2:0]  h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_sel;
    logic        h_stall;
    logic [31:0] h_rdata;
    logic        wb_stb, wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdata = 32'd0;
    logic        hack, update, locked, overrun;
    logic [15:0] phase_err;

    logic [15:0] ck_phase = 16'd0;
    logic [31:0] ck_speed = 32'd0;

    bus_t        exp_bus[$];
    logic [15:0] exp_upd[$];
    int          checks = 0;
    int          errors = 0;
    int          hack_cnt = 0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    rtc_pps_discipline dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_pps(pps),
        .i_host_stb(h_stb), .i_host_we(h_we), .i_host_addr(h_addr),
        .i_host_data(h_data), .i_host_sel(h_sel), .o_host_stall(h_stall),
        .o_host_data(h_rdata), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_wb_sel(wb_sel),
        .i_wb_data(wb_rdata), .o_hack(hack), .o_phase_err(phase_err),
        .o_update(update), .o_locked(locked), .o_overrun(overrun)
    );

    // Clock register model: read data appears the cycle after a strobe.
    always @(posedge clk) begin
        if (wb_stb) begin
            case (wb_addr)
                3'd4:    wb_rdata <= ck_speed;
                3'd5:    wb_rdata <= {24'd0, ck_phase[15:8]};
                3'd6:    wb_rdata <= {ck_phase[7:0], 24'd0};
                default: wb_rdata <= 32'd0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pps_pulse();
        @(posedge clk); #1 pps = 1'b1;
        @(posedge clk); #1 pps = 1'b0;
    endtask

    // mode 0 plain, 1 host strobe in RD_CNT, 2 second PPS in WAIT2, 3 reset in RD_SPD
    task automatic run_seq(input logic [15:0] phase, input logic [31:0] speed,
                           input int mode, input logic [31:0] exp_wr);
        int h0;
        bit done;
        ck_phase = phase;
        ck_speed = speed;
        exp_bus.push_back({1'b0, 3'd5, 32'd0});
        exp_bus.push_back({1'b0, 3'd6, 32'd0});
        exp_bus.push_back({1'b0, 3'd4, 32'd0});
        if (mode != 3) begin
            exp_bus.push_back({1'b1, 3'd4, exp_wr});
            exp_upd.push_back(phase);
        end
        h0 = hack_cnt;
        done = 1'b0;
        pps_pulse();
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (mode == 1 && wb_stb && !wb_we && wb_addr == 3'd6) begin
                h_stb = 1'b1; h_we = 1'b1; h_addr = 3'd2; h_data = 32'hDEAD_0002;
                #1;
                chk("arb_stall", 32'(h_stall), 32'd1);
                chk("arb_addr", 32'(wb_addr), 32'd6);
                chk("arb_we", 32'(wb_we), 32'd0);
                @(posedge clk); #1 h_stb = 1'b0;
            end
            if (mode == 2 && hack) begin
                pps = 1'b1;
                @(posedge clk); #1 pps = 1'b0;
            end
            if (mode == 3 && wb_stb && !wb_we && wb_addr == 3'd4) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_wb_stb", 32'(wb_stb), 32'd0);
                chk("rst_hack", 32'(hack), 32'd0);
                chk("rst_update", 32'(update), 32'd0);
                chk("rst_phase_err", 32'(phase_err), 32'd0);
                chk("rst_locked", 32'(locked), 32'd0);
                done = 1'b1;
            end
            if (update) done = 1'b1;
        end
        if (!done) chk("seq_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("hack_pulses", 32'(hack_cnt), 32'(h0 + 1));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pps = 1'b0;
        h_stb = 1'b0; h_we = 1'b0; h_addr = 3'd0; h_data = 32'd0; h_sel = 4'd0;

        fork
            begin : monitor
                bus_t e;
                forever begin
                    @(negedge clk);
                    if (wb_stb) begin
                        if (wb_we) wr_cnt++;
                        if (exp_bus.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL bus_unexpected: addr %0d we %0b data 0x%08h at %0t",
                                     wb_addr, wb_we, wb_data, $time);
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_we", 32'(wb_we), 32'(e.we));
                            chk("bus_addr", 32'(wb_addr), 32'(e.addr));
                            if (e.we) chk("bus_wdata", wb_data, e.data);
                        end
                    end
                    if (hack) hack_cnt++;
                    if (update) begin
                        if (exp_upd.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL update_unexpected: phase_err 0x%04h at %0t", phase_err, $time);
                        end else begin
                            chk("phase_err", 32'(phase_err), 32'(exp_upd.pop_front()));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hack", 32'(hack), 32'd0);
        chk("reset_update", 32'(update), 32'd0);
        chk("reset_stall", 32'(h_stall), 32'd0);
        chk("reset_phase_err", 32'(phase_err), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Host write while idle passes straight through.
        exp_bus.push_back({1'b1, 3'd2, 32'hA5A5_0001});
        #1 h_stb = 1'b1; h_we = 1'b1; h_addr = 3'd2; h_data = 32'hA5A5_0001; h_sel = 4'h3;
        #1;
        chk("idle_stall", 32'(h_stall), 32'd0);
        chk("idle_sel", 32'(wb_sel), 32'h3);
        @(posedge clk); #1 h_stb = 1'b0; h_we = 1'b0;
        repeat (2) @(posedge clk);

        run_seq(16'hFF80, 32'd2814750, 0, 32'd2814758);
        run_seq(16'h0100, 32'd2814750, 0, 32'd2814734);
        run_seq(16'h4000, 32'd2814750, 0, 32'd2814494);
        run_seq(16'hC000, 32'd2814750, 0, 32'd2815006);
        run_seq(16'h0050, 32'd5,       0, 32'd1);

        for (int i = 0; i < 4; i++) begin
            chk("lock_before", 32'(locked), 32'd0);
            run_seq(16'h0010, 32'd2814750, 0, 32'd2814749);
        end
        chk("lock_after4", 32'(locked), 32'd1);
        run_seq(16'h0100, 32'd2814750, 0, 32'd2814734);
        chk("unlock", 32'(locked), 32'd0);

        run_seq(16'h0020, 32'd2814750, 1, 32'd2814748);

        chk("overrun_before", 32'(overrun), 32'd0);
        run_seq(16'hFFF0, 32'd2814750, 2, 32'd2814751);
        repeat (10) @(posedge clk);
        #1 chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_one_write", 32'(exp_bus.size()), 32'd0);

        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("overrun_held", 32'(overrun), 32'd1);
        begin
            int h0;
            h0 = hack_cnt;
            pps_pulse();
            repeat (20) @(posedge clk);
            #1 chk("disabled_no_hack", 32'(hack_cnt), 32'(h0));
        end
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("overrun_cleared", 32'(overrun), 32'd0);

        run_seq(16'h0100, 32'd2814750, 3, 32'd0);
        begin
            int w0;
            w0 = wr_cnt;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (30) @(posedge clk);
            #1 chk("no_write_after_reset", 32'(wr_cnt), 32'(w0));
        end
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        chk("upd_queue_empty", 32'(exp_upd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
